// File: rtl/seq_long_div_if.sv
// Operand/result bundle for the sequential long divider.
// The master side presents operands; the slave side (the divider) returns results.
interface seq_long_div_if #(
  parameter int size_in  = 64,
  parameter int size_out = 2*size_in
);
  logic                valid_in;
  logic                ready_out;
  logic [size_out-1:0] dividend_in;
  logic [size_in-1:0]  divisor_in;
  logic                valid_out;
  logic [size_out-1:0] quotient_out;
  logic [size_in-1:0]  remainder_out;
  logic                div_zero_out;

  modport master (
    output valid_in, dividend_in, divisor_in,
    input  ready_out, valid_out, quotient_out, remainder_out, div_zero_out
  );

  modport slave (
    input  valid_in, dividend_in, divisor_in,
    output ready_out, valid_out, quotient_out, remainder_out, div_zero_out
  );
endinterface

// File: rtl/seq_long_div.sv
// Restoring long divider: 2N-bit dividend / N-bit divisor, one quotient bit
// per clock, MSB first. Fixed latency regardless of operand values, including
// a zero divisor.
module seq_long_div #(
  parameter int size_in  = 64,
  parameter int size_out = 2*size_in
) (
  input logic           clk_in,
  input logic           rst_in,
  seq_long_div_if.slave bus
);
  localparam int CW = $clog2(size_out);
  localparam int RW = size_in + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  // Dividend bits shift out of the top while quotient bits shift in at the
  // bottom, so after size_out steps this register holds the quotient.
  logic [size_out-1:0] dvd_q;
  logic [size_in-1:0]  dsr_q;
  logic [RW-1:0]       rem_q;
  logic [RW:0]         rem_sh;
  logic [RW-1:0]       rem_nx;
  logic                ge;
  logic [CW-1:0]       cnt_q;
  logic                accept, last;
  logic [size_out-1:0] quo_out_q;
  logic [size_in-1:0]  rem_out_q;
  logic                dz_q;

  assign accept = (state_q == IDLE) && bus.valid_in;
  assign last   = (state_q == RUN) && (cnt_q == CW'(size_out-1));

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, dvd_q[size_out-1]};
    ge     = (rem_sh >= {2'b00, dsr_q});
    rem_nx = ge ? RW'(rem_sh - {2'b00, dsr_q}) : RW'(rem_sh);
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.valid_in) state_d = RUN;
      RUN:     if (last)         state_d = DONE;
      DONE:                      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registration.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dz_q      <= 1'b0;
    end else if (accept) begin
      dvd_q <= bus.dividend_in;
      dsr_q <= bus.divisor_in;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      dvd_q <= {dvd_q[size_out-2:0], ge};
      rem_q <= rem_nx;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        // A zero divisor naturally yields all-ones quotient bits; only the
        // remainder needs overriding.
        if (dsr_q == '0) begin
          quo_out_q <= '1;
          rem_out_q <= '0;
          dz_q      <= 1'b1;
        end else begin
          quo_out_q <= {dvd_q[size_out-2:0], ge};
          rem_out_q <= rem_nx[size_in-1:0];
          dz_q      <= 1'b0;
        end
      end
    end
  end

  assign bus.ready_out     = (state_q == IDLE);
  assign bus.valid_out     = (state_q == DONE);
  assign bus.quotient_out  = quo_out_q;
  assign bus.remainder_out = rem_out_q;
  assign bus.div_zero_out  = dz_q;
endmodule

// File: tb/tb_seq_long_div.sv
// Directed and randomised checks for seq_long_div with size_in = 8.
module tb_seq_long_div;
  localparam int SI = 8;
  localparam int SO = 16;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  seq_long_div_if #(.size_in(SI), .size_out(SO)) bus();
  seq_long_div #(.size_in(SI), .size_out(SO)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    int          acc;
  } op_t;

  // Run one operation; returns results and edges from accept to valid_out.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r,
                       output logic dz, output int lat);
    int n;
    n = 0;
    while (!bus.ready_out && n < 100) begin
      @(posedge clk_in); #1; n++;
    end
    bus.valid_in    = 1'b1;
    bus.dividend_in = a;
    bus.divisor_in  = b;
    @(posedge clk_in); #1;
    bus.valid_in    = 1'b0;
    bus.dividend_in = 16'($urandom);
    bus.divisor_in  = 8'($urandom);
    lat = 0;
    while (!bus.valid_out && lat < 100) begin
      @(posedge clk_in); #1; lat++;
    end
    q  = bus.quotient_out;
    r  = bus.remainder_out;
    dz = bus.div_zero_out;
  endtask

  task automatic test_reset();
    rst_in          = 1'b1;
    bus.valid_in    = 1'b0;
    bus.dividend_in = '0;
    bus.divisor_in  = '0;
    repeat (2) @(posedge clk_in);
    #1;
    vectors++; if (bus.ready_out !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", bus.ready_out); end
    vectors++; if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", bus.valid_out); end
    vectors++; if (bus.quotient_out !== 16'h0) begin miscompares++; $display("FAIL reset_quot got %h exp 0", bus.quotient_out); end
    vectors++; if (bus.remainder_out !== 8'h0) begin miscompares++; $display("FAIL reset_rem got %h exp 0", bus.remainder_out); end
    vectors++; if (bus.div_zero_out !== 1'b0) begin miscompares++; $display("FAIL reset_dz got %b exp 0", bus.div_zero_out); end
    rst_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_basic();
    logic [15:0] q; logic [7:0] r; logic dz; int lat;
    do_op(16'd1000, 8'd7, q, r, dz, lat);
    vectors++; if (lat != 16) begin miscompares++; $display("FAIL basic_latency got %0d exp 16", lat); end
    vectors++; if (q !== 16'd142) begin miscompares++; $display("FAIL basic_quot got %0d exp 142", q); end
    vectors++; if (r !== 8'd6) begin miscompares++; $display("FAIL basic_rem got %0d exp 6", r); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL basic_dz got %b exp 0", dz); end
    @(posedge clk_in); #1;
    vectors++; if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL basic_pulse_width got %b exp 0", bus.valid_out); end
    vectors++; if (bus.ready_out !== 1'b1) begin miscompares++; $display("FAIL basic_ready_after got %b exp 1", bus.ready_out); end
  endtask

  task automatic test_edges();
    logic [15:0] q; logic [7:0] r; logic dz; int lat;
    do_op(16'hFFFF, 8'hFF, q, r, dz, lat);
    vectors++; if (q !== 16'h0101) begin miscompares++; $display("FAIL max_quot got %h exp 0101", q); end
    vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL max_rem got %h exp 00", r); end
    do_op(16'd5, 8'd9, q, r, dz, lat);
    vectors++; if (q !== 16'd0) begin miscompares++; $display("FAIL small_quot got %0d exp 0", q); end
    vectors++; if (r !== 8'd5) begin miscompares++; $display("FAIL small_rem got %0d exp 5", r); end
    repeat (4) @(posedge clk_in);
    #1;
    vectors++; if (bus.quotient_out !== 16'd0 || bus.remainder_out !== 8'd5) begin
      miscompares++; $display("FAIL hold_outputs got q=%0d r=%0d exp q=0 r=5", bus.quotient_out, bus.remainder_out);
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] q; logic [7:0] r; logic dz; int lat;
    do_op(16'h1234, 8'd0, q, r, dz, lat);
    vectors++; if (lat != 16) begin miscompares++; $display("FAIL dz_latency got %0d exp 16", lat); end
    vectors++; if (q !== 16'hFFFF) begin miscompares++; $display("FAIL dz_quot got %h exp FFFF", q); end
    vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL dz_rem got %h exp 00", r); end
    vectors++; if (dz !== 1'b1) begin miscompares++; $display("FAIL dz_flag got %b exp 1", dz); end
    @(posedge clk_in); #1;
  endtask

  task automatic test_back_to_back();
    op_t qu[$];
    op_t e;
    logic [15:0] a; logic [7:0] b;
    int accepts, results;
    accepts = 0; results = 0;
    for (int i = 0; i < 110; i++) begin
      if (bus.valid_out) begin
        results++;
        if (qu.size() == 0) begin
          vectors++; miscompares++; $display("FAIL b2b_unexpected_result at iter %0d", i);
        end else begin
          e = qu.pop_front();
          vectors++;
          if (bus.quotient_out !== e.a / e.b || bus.remainder_out !== e.a % e.b || (i - e.acc) != 16) begin
            miscompares++;
            $display("FAIL b2b_result got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=16",
                     bus.quotient_out, bus.remainder_out, i - e.acc, e.a / e.b, e.a % e.b);
          end
        end
      end
      a = 16'(1000 + i*37);
      b = 8'(i % 13 + 1);
      bus.valid_in    = (i < 92);
      bus.dividend_in = a;
      bus.divisor_in  = b;
      if (bus.ready_out && i < 92) begin
        qu.push_back('{a: a, b: b, acc: i + 1});
        accepts++;
      end
      @(posedge clk_in); #1;
    end
    bus.valid_in = 1'b0;
    vectors++; if (qu.size() != 0 || results != accepts) begin
      miscompares++; $display("FAIL b2b_drain got results=%0d exp %0d", results, accepts);
    end
    vectors++; if (accepts < 5 || accepts > 6) begin
      miscompares++; $display("FAIL b2b_accept_count got %0d exp 5..6", accepts);
    end
  endtask

  task automatic test_abort();
    logic [15:0] q; logic [7:0] r; logic dz; int lat, seen;
    do_op(16'd1000, 8'd7, q, r, dz, lat);
    @(posedge clk_in); #1;
    bus.valid_in    = 1'b1;
    bus.dividend_in = 16'hABCD;
    bus.divisor_in  = 8'd5;
    @(posedge clk_in); #1;
    bus.valid_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    vectors++; if (bus.ready_out !== 1'b0) begin miscompares++; $display("FAIL abort_in_run got ready=%b exp 0", bus.ready_out); end
    rst_in = 1'b1;
    #1;
    vectors++; if (bus.ready_out !== 1'b1) begin miscompares++; $display("FAIL abort_ready got %b exp 1", bus.ready_out); end
    vectors++; if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL abort_valid got %b exp 0", bus.valid_out); end
    vectors++; if (bus.quotient_out !== 16'h0 || bus.remainder_out !== 8'h0 || bus.div_zero_out !== 1'b0) begin
      miscompares++; $display("FAIL abort_outputs got q=%h r=%h dz=%b exp 0", bus.quotient_out, bus.remainder_out, bus.div_zero_out);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.valid_out) seen++;
      @(posedge clk_in); #1;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL abort_no_pulse got %0d pulses exp 0", seen); end
    do_op(16'd200, 8'd3, q, r, dz, lat);
    vectors++; if (q !== 16'd66 || r !== 8'd2 || dz !== 1'b0 || lat != 16) begin
      miscompares++; $display("FAIL abort_next_op got q=%0d r=%0d dz=%b lat=%0d exp 66 2 0 16", q, r, dz, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] q, a; logic [7:0] r, b; logic dz; int lat;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 8'($urandom);
      if (i % 50 == 0) b = 8'd1;
      if (i % 50 == 1) a = 16'd0;
      if (i % 97 == 5) b = 8'd0;
      do_op(a, b, q, r, dz, lat);
      vectors++;
      if (b == 8'd0) begin
        if (q !== 16'hFFFF || r !== 8'd0 || dz !== 1'b1) begin
          miscompares++; $display("FAIL rand_dz a=%h got q=%h r=%h dz=%b", a, q, r, dz);
        end
      end else if ((int'(q) * int'(b) + int'(r)) != int'(a) || r >= b || dz !== 1'b0) begin
        miscompares++; $display("FAIL rand_op %0d/%0d got q=%0d r=%0d dz=%b", a, b, q, r, dz);
      end
      vectors++; if (lat != 16) begin miscompares++; $display("FAIL rand_latency got %0d exp 16", lat); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    @(posedge clk_in); #1;
    test_back_to_back();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
